// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operation is resolved CHUNK bits per
// clock through one ripple slice, with the inter-chunk carry held in a flop.
module chunked_adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("chunked_adder_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // Handshake semantics: an operand transfer happens on an edge where
    // in_valid && in_ready; a result transfer on an edge where
    // out_valid && out_ready. Both ready/valid outputs are registered.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q, cout_q, ovf_q, in_ready_q, out_valid_q;

    logic [31:0]      chunk_base;
    logic [WIDTH-1:0] a_shift, b_shift, sum_d;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   slice_d;
    logic             carry_msb_in;

    always_comb begin
        chunk_base   = 32'(idx_q) * CHUNK;
        a_shift      = a_q >> chunk_base;
        b_shift      = b_q >> chunk_base;
        a_chunk      = a_shift[CHUNK-1:0];
        b_chunk      = b_shift[CHUNK-1:0];
        slice_d      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out.
        carry_msb_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ slice_d[CHUNK-1];
        sum_d        = (sum_q & ~(CHUNK_MASK << chunk_base))
                     | (WIDTH'(slice_d[CHUNK-1:0]) << chunk_base);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~cin, so invert both at capture.
                        a_q        <= A;
                        b_q        <= sub ? ~B : B;
                        carry_q    <= cin ^ sub;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_d[CHUNK];
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_d[CHUNK];
                        ovf_q       <= carry_msb_in ^ slice_d[CHUNK];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Bench for chunked_adder_seq: four instances (16/4, 16/1, 16/16, 32/8) share one
// stimulus stream; directed table on 16/4, then random sweep against a golden model.
module tb_chunked_adder_seq;

    localparam int ND = 4;
    localparam int W  = 34;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, cin, sub, out_ready;
    logic [31:0] a_in, b_in;

    logic [ND-1:0] ir, ov, co, of;
    logic [15:0]   s0, s1, s2;
    logic [31:0]   s3;
    logic [1:0]    st0, st1, st2, st3;
    logic [31:0]   sum_v [ND];

    int dut_w   [ND] = '{16, 16, 16, 32};
    int dut_lat [ND] = '{4, 16, 1, 4};
    int lat_v   [ND];

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    always_comb begin
        sum_v[0] = {16'h0, s0};
        sum_v[1] = {16'h0, s1};
        sum_v[2] = {16'h0, s2};
        sum_v[3] = s3;
    end

    chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .A(a_in[15:0]), .B(b_in[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready), .Sum(s0), .cout(co[0]),
        .ovf(of[0]), .state_o(st0));
    chunked_adder_seq #(.WIDTH(16), .CHUNK(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .A(a_in[15:0]), .B(b_in[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready), .Sum(s1), .cout(co[1]),
        .ovf(of[1]), .state_o(st1));
    chunked_adder_seq #(.WIDTH(16), .CHUNK(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .A(a_in[15:0]), .B(b_in[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready), .Sum(s2), .cout(co[2]),
        .ovf(of[2]), .state_o(st2));
    chunked_adder_seq #(.WIDTH(32), .CHUNK(8)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
        .A(a_in), .B(b_in), .cin(cin), .sub(sub),
        .out_valid(ov[3]), .out_ready(out_ready), .Sum(s3), .cout(co[3]),
        .ovf(of[3]), .state_o(st3));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        s;
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: plain wide addition, sign-rule overflow.
    function automatic logic [W-1:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input logic s);
        logic [32:0] full;
        logic [31:0] mask, am, bm, sm;
        logic        co_m, ov_m;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = a & mask;
        bm   = (s ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, bm} + {32'h0, c ^ s};
        sm   = full[31:0] & mask;
        co_m = full[w];
        ov_m = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        return {ov_m, co_m, sm};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic s, input bit scramble);
        int k;
        bit done_all;
        @(negedge clk);
        a_in = a; b_in = b; cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int d = 0; d < ND; d++) lat_v[d] = -1;
        k = 0;
        done_all = 1'b0;
        while (!done_all && k < 40) begin
            for (int d = 0; d < ND; d++) check($sformatf("in_ready_busy_d%0d", d), {31'b0, ir[d]}, 0);
            if (scramble) begin
                a_in = $urandom; b_in = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
            k++;
            done_all = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (ov[d] && lat_v[d] < 0) lat_v[d] = k;
                if (lat_v[d] < 0) done_all = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (!done_all) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: out_valid=0x%0h after %0d cycles, required 0xf", ov, k);
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("release_out_valid_d%0d", d), {31'b0, ov[d]}, 0);
            check($sformatf("release_in_ready_d%0d", d), {31'b0, ir[d]}, 1);
        end
    endtask

    task automatic check_all(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        logic [W-1:0] e;
        for (int d = 0; d < ND; d++) exp_q.push_back(model(dut_w[d], a, b, c, s));
        for (int d = 0; d < ND; d++) begin
            e = exp_q.pop_front();
            check($sformatf("sum_d%0d", d), sum_v[d], e[31:0]);
            check($sformatf("cout_d%0d", d), {31'b0, co[d]}, {31'b0, e[32]});
            check($sformatf("ovf_d%0d", d), {31'b0, of[d]}, {31'b0, e[33]});
            check($sformatf("latency_d%0d", d), lat_v[d], dut_lat[d]);
        end
    endtask

    task automatic check_main(input string tag, input logic [15:0] sum, input logic c, input logic o);
        check({tag, "_sum"}, {16'h0, s0}, {16'h0, sum});
        check({tag, "_cout"}, {31'b0, co[0]}, {31'b0, c});
        check({tag, "_ovf"}, {31'b0, of[0]}, {31'b0, o});
        check({tag, "_latency"}, lat_v[0], 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0007, 16'h0001, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h000A, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[8] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

        // Clock/reset
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {30'b0, st0}, 0);
        check("reset_in_ready", {31'b0, ir[0]}, 1);
        check("reset_out_valid", {31'b0, ov[0]}, 0);
        check("reset_sum", {16'h0, s0}, 0);
        check("reset_cout", {31'b0, co[0]}, 0);
        check("reset_ovf", {31'b0, of[0]}, 0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op({16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].c, tbl[i].s, 1'b0);
            check_main($sformatf("vec%0d", i), tbl[i].sum, tbl[i].co, tbl[i].ov);
            check_all({16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].c, tbl[i].s);
            release_op();
        end

        // Backpressure with inputs scrambled through RUN and DONE: 0x1234-0x0FF0
        run_op(32'h1234, 32'h0FF0, 1'b0, 1'b1, 1'b1);
        check_main("bp", 16'h0244, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a_in = $urandom; b_in = $urandom; in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_out_valid", {31'b0, ov[0]}, 1);
            check("bp_hold_sum", {16'h0, s0}, 32'h0244);
            check("bp_hold_cout", {31'b0, co[0]}, 1);
            check("bp_hold_ovf", {31'b0, of[0]}, 0);
        end
        in_valid = 1'b0;
        release_op();
        run_op(32'h00FF, 32'h0001, 1'b0, 1'b0, 1'b0);
        check_main("after_bp", 16'h0100, 1'b0, 1'b0);
        release_op();

        // Reset while the 16/4 instance is at RUN idx=2
        @(negedge clk);
        a_in = 32'hAAAA; b_in = 32'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_state", {30'b0, st0}, 0);
        check("midrst_in_ready", {31'b0, ir[0]}, 1);
        check("midrst_out_valid", {31'b0, ov[0]}, 0);
        check("midrst_sum", {16'h0, s0}, 0);
        rst_n = 1'b1;
        run_op(32'h1234, 32'h4321, 1'b0, 1'b0, 1'b0);
        check_main("post_rst", 16'h5555, 1'b0, 1'b0);
        release_op();

        // Random sweep over all four parameterisations
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic rc, rs;
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, rs, 1'b0);
            check_all(ra, rb, rc, rs);
            release_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
